// File: rtl/nand3_switch_cell_if.sv
// nand3_switch_cell_if: stimulus and observation bundle for the NAND3 switch-level cell.
interface nand3_switch_cell_if #(parameter int CNT_W = 16);
   logic             en;
   logic             a;
   logic             b;
   logic             c;
   logic [5:0]       fault_open;
   logic [5:0]       fault_short;
   logic             cnt_clr;
   logic             y;
   logic             pu_on;
   logic             pd_on;
   logic             contention;
   logic             floating;
   logic [CNT_W-1:0] toggle_cnt;
   modport master (
      output en, a, b, c, fault_open, fault_short, cnt_clr,
      input  y, pu_on, pd_on, contention, floating, toggle_cnt
   );
   modport slave (
      input  en, a, b, c, fault_open, fault_short, cnt_clr,
      output y, pu_on, pd_on, contention, floating, toggle_cnt
   );
endinterface

// File: rtl/nand3_switch_cell.sv
// nand3_switch_cell: clocked switch-level CMOS NAND3 with fault injection,
// contention/floating detection and a saturating output toggle counter.
module nand3_switch_cell #(
   parameter int   CNT_W = 16,
   parameter logic Y_RST = 1'b1
) (
   input logic                clk,
   input logic                rst_n,
   nand3_switch_cell_if.slave bus
);
   logic [5:0]       gate;
   logic [5:0]       on;
   logic             pu;
   logic             pd;
   logic             y_new;
   logic             y_d, y_q;
   logic             pu_d, pu_q;
   logic             pd_d, pd_q;
   logic             cont_d, cont_q;
   logic             float_d, float_q;
   logic [CNT_W-1:0] cnt_d, cnt_q;
   always_comb begin
      // bits 0..2 are the series NMOS stack, 3..5 the parallel PMOS devices
      gate    = {bus.c, bus.b, bus.a, bus.a, bus.b, bus.c};
      on      = '0;
      on[2:0] = bus.fault_short[2:0] | (gate[2:0] & ~bus.fault_open[2:0]);
      on[5:3] = bus.fault_short[5:3] | (~gate[5:3] & ~bus.fault_open[5:3]);
      pd      = &on[2:0];
      pu      = |on[5:3];
      // NMOS wins a fight; with no path the output node keeps its charge
      y_new   = pd ? 1'b0 : pu ? 1'b1 : y_q;
      y_d     = bus.en ? y_new : y_q;
      pu_d    = bus.en ? pu : pu_q;
      pd_d    = bus.en ? pd : pd_q;
      cont_d  = bus.en ? (pu & pd) : cont_q;
      float_d = bus.en ? ~(pu | pd) : float_q;
      cnt_d   = bus.cnt_clr ? '0 :
                (bus.en && (y_new != y_q) && (cnt_q != '1)) ? cnt_q + {{(CNT_W-1){1'b0}}, 1'b1} :
                cnt_q;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         y_q     <= Y_RST;
         pu_q    <= 1'b0;
         pd_q    <= 1'b0;
         cont_q  <= 1'b0;
         float_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         y_q     <= y_d;
         pu_q    <= pu_d;
         pd_q    <= pd_d;
         cont_q  <= cont_d;
         float_q <= float_d;
         cnt_q   <= cnt_d;
      end
   end
   assign bus.y          = y_q;
   assign bus.pu_on      = pu_q;
   assign bus.pd_on      = pd_q;
   assign bus.contention = cont_q;
   assign bus.floating   = float_q;
   assign bus.toggle_cnt = cnt_q;
endmodule

// File: tb/tb_nand3_switch_cell.sv
// tb_nand3_switch_cell: directed vectors for the NAND3 switch cell, plus a
// narrow-counter instance for saturation.
module tb_nand3_switch_cell;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;
   always #5 clk = ~clk;
   nand3_switch_cell_if #(.CNT_W(16)) bus ();
   nand3_switch_cell_if #(.CNT_W(2))  bus2 ();
   nand3_switch_cell #(.CNT_W(16), .Y_RST(1'b1)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   nand3_switch_cell #(.CNT_W(2),  .Y_RST(1'b1)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic apply(input logic [2:0] abc);
      {bus.a, bus.b, bus.c} = abc;
      @(posedge clk);
      #1;
   endtask
   task automatic flags(input string tag, input logic y, input logic pu, input logic pd,
                        input logic ct, input logic fl);
      check({tag, ".y"},    32'(bus.y),          32'(y));
      check({tag, ".pu"},   32'(bus.pu_on),      32'(pu));
      check({tag, ".pd"},   32'(bus.pd_on),      32'(pd));
      check({tag, ".cont"}, 32'(bus.contention), 32'(ct));
      check({tag, ".flt"},  32'(bus.floating),   32'(fl));
   endtask
   initial begin
      bus.en = 1'b0; bus.cnt_clr = 1'b0; bus.fault_open = '0; bus.fault_short = '0;
      {bus.a, bus.b, bus.c} = 3'b000;
      bus2.en = 1'b0; bus2.cnt_clr = 1'b0; bus2.fault_open = '0; bus2.fault_short = '0;
      {bus2.a, bus2.b, bus2.c} = 3'b000;
      repeat (2) @(posedge clk);
      #1;
      flags("rst", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      check("rst.cnt", 32'(bus.toggle_cnt), 0);
      rst_n = 1'b1;
      bus.en = 1'b1;
      for (int v = 0; v < 8; v++) begin
         apply(3'(v));
         flags($sformatf("tt%0d", v), v != 7, v != 7, v == 7, 1'b0, 1'b0);
      end
      check("tt.cnt", 32'(bus.toggle_cnt), 1);
      bus.cnt_clr = 1'b1;
      apply(3'b000);
      bus.cnt_clr = 1'b0;
      check("clr.cnt", 32'(bus.toggle_cnt), 0);
      for (int k = 1; k <= 16; k++) apply(3'(k));
      check("tog.cnt", 32'(bus.toggle_cnt), 4);
      bus.cnt_clr = 1'b1;
      apply(3'b111);
      bus.cnt_clr = 1'b0;
      check("clrtog.y", 32'(bus.y), 0);
      check("clrtog.cnt", 32'(bus.toggle_cnt), 0);
      apply(3'b000);
      check("aftclr.cnt", 32'(bus.toggle_cnt), 1);
      bus.fault_open = 6'b111000;
      apply(3'b111);
      flags("open1", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      apply(3'b000);
      flags("open0", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      check("open.cnt", 32'(bus.toggle_cnt), 2);
      bus.fault_open = '0;
      bus.fault_short = 6'b000111;
      apply(3'b000);
      flags("short0", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
      apply(3'b111);
      flags("short1", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      bus.fault_short = 6'b000001;
      bus.fault_open = 6'b000001;
      apply(3'b110);
      flags("dom", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
      bus.fault_short = '0;
      bus.fault_open = '0;
      apply(3'b000);
      check("en.y1", 32'(bus.y), 1);
      check("en.cnt1", 32'(bus.toggle_cnt), 3);
      bus.en = 1'b0;
      bus.fault_short = 6'b111111;
      apply(3'b111);
      flags("hold", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      check("hold.cnt", 32'(bus.toggle_cnt), 3);
      bus.cnt_clr = 1'b1;
      apply(3'b111);
      bus.cnt_clr = 1'b0;
      check("clren.cnt", 32'(bus.toggle_cnt), 0);
      check("clren.y", 32'(bus.y), 1);
      bus.en = 1'b1;
      bus.fault_short = '0;
      apply(3'b111);
      check("pre.y", 32'(bus.y), 0);
      check("pre.cnt", 32'(bus.toggle_cnt), 1);
      #3;
      rst_n = 1'b0;
      #1;
      check("arst.y", 32'(bus.y), 1);
      check("arst.cnt", 32'(bus.toggle_cnt), 0);
      check("arst.pd", 32'(bus.pd_on), 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      bus.en = 1'b0;
      bus2.en = 1'b1;
      for (int i = 0; i < 5; i++) begin
         {bus2.a, bus2.b, bus2.c} = (i % 2 == 0) ? 3'b111 : 3'b000;
         @(posedge clk);
         #1;
         check($sformatf("sat%0d.y", i), 32'(bus2.y), (i % 2 == 0) ? 0 : 1);
         check($sformatf("sat%0d.cnt", i), 32'(bus2.toggle_cnt), (i < 3) ? i + 1 : 3);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
